// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point requester blocks.
// Holds the requester FSM states and the saturation constant generator.
package fixed_point_pkg;

  localparam int ERR_COUNT_W = 8;
  localparam int TIMER_W     = 8;
  localparam int SAT_MAX_W   = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Largest positive or most negative two's-complement value of the given width, LSB-aligned.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int width);
    logic [SAT_MAX_W-1:0] maxPos;
    maxPos = (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    return sign ? ~maxPos : maxPos;
  endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Combinational clamp of a fixed-point result after an overflowing operation.
// The sign input chooses the rail: 0 selects the largest positive value, 1 the most negative.
module fixed_point_saturate
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_overflow,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if ((SATURATE != 0) && i_overflow) begin
      o_val = WIDTH'(sat_value(i_sign, WIDTH));
    end
  end

endmodule

// File: rtl/fixed_point_add_requester.sv
// Initiator for a FixedPointAdder: accepts operand pairs, pulses start, waits for done with a
// timeout, optionally saturates, and returns result/overflow/error on a valid/ready stream.
module fixed_point_add_requester
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FBITS    = 4,
  parameter int TIMEOUT  = 15,
  parameter int SATURATE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [WIDTH-1:0]       i_req_a,
  input  logic [WIDTH-1:0]       i_req_b,
  output logic                   o_start,
  output logic [WIDTH-1:0]       o_operandA,
  output logic [WIDTH-1:0]       o_operandB,
  input  logic                   i_busy,
  input  logic                   i_done,
  input  logic                   i_valid,
  input  logic                   i_overflow,
  input  logic [WIDTH-1:0]       i_val,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [WIDTH-1:0]       o_rsp_val,
  output logic                   o_rsp_overflow,
  output logic                   o_rsp_error,
  output logic [ERR_COUNT_W-1:0] o_err_count
);

  localparam logic [TIMER_W-1:0] LAST_WAIT = TIMER_W'(TIMEOUT - 1);

  if (FBITS < 0 || FBITS >= WIDTH) begin : g_bad_fbits
    $error("fixed_point_add_requester: FBITS must lie in 0..WIDTH-1");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fixed_point_add_requester: TIMEOUT must lie in 1..255");
  end

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       opA_q, opA_d;
  logic [WIDTH-1:0]       opB_q, opB_d;
  logic [WIDTH-1:0]       rspVal_q, rspVal_d;
  logic                   rspOvf_q, rspOvf_d;
  logic                   rspErr_q, rspErr_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [ERR_COUNT_W-1:0] errCount_q, errCount_d;
  logic [WIDTH-1:0]       satVal;

  fixed_point_saturate #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_saturate (
    .i_val     (i_val),
    .i_overflow(i_overflow),
    .i_sign    (opA_q[WIDTH-1]),
    .o_val     (satVal)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      rspVal_q   <= '0;
      rspOvf_q   <= 1'b0;
      rspErr_q   <= 1'b0;
      timer_q    <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      rspVal_q   <= rspVal_d;
      rspOvf_q   <= rspOvf_d;
      rspErr_q   <= rspErr_d;
      timer_q    <= timer_d;
      errCount_q <= errCount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    rspVal_d   = rspVal_q;
    rspOvf_d   = rspOvf_q;
    rspErr_d   = rspErr_q;
    timer_d    = timer_q;
    errCount_d = errCount_q;
    o_start    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          opA_d   = i_req_a;
          opB_d   = i_req_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!i_busy) begin
          o_start = 1'b1;
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        // A done landing on the final timer cycle still wins over the timeout.
        if (i_done) begin
          state_d  = RESP;
          rspOvf_d = i_overflow;
          if (i_valid) begin
            rspVal_d = satVal;
            rspErr_d = 1'b0;
          end else begin
            rspVal_d = '0;
            rspErr_d = 1'b1;
          end
        end else if (timer_q == LAST_WAIT) begin
          state_d  = RESP;
          rspVal_d = '0;
          rspOvf_d = 1'b0;
          rspErr_d = 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
          if (rspErr_q && (errCount_q != '1)) begin
            errCount_d = errCount_q + ERR_COUNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign o_req_ready    = (state_q == IDLE) && i_rst_n;
  assign o_operandA     = opA_q;
  assign o_operandB     = opB_q;
  assign o_rsp_valid    = (state_q == RESP);
  assign o_rsp_val      = rspVal_q;
  assign o_rsp_overflow = rspOvf_q;
  assign o_rsp_error    = rspErr_q;
  assign o_err_count    = errCount_q;

endmodule
